// File: rtl/cache_refill_controller.sv
// cache_refill_controller: load-miss handler between the CPU load path and the two-way data cache.
// Optional hit/miss statistics counters are compiled in with CACHE_REFILL_STATS_EN.
module cache_refill_controller #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  cache_hit_i,
  input  logic [DATA_WIDTH-1:0] cache_data_i,
  output logic                  stall_o,
  output logic                  load_valid_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  fill_o,
  output logic [ADDR_WIDTH-1:0] fill_addr_o,
  output logic [DATA_WIDTH-1:0] fill_data_o,
`ifdef CACHE_REFILL_STATS_EN
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o,
`endif
  output logic                  timeout_o
);

  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  hit_evt, miss_evt;

  // Byte offset is dropped: memory and fill traffic is word-aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
    hit_evt      = 1'b0;
    miss_evt     = 1'b0;
    stall_o      = 1'b0;
    load_valid_o = 1'b0;
    load_data_o  = '0;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    fill_o       = 1'b0;
    fill_addr_o  = '0;
    fill_data_o  = '0;
    timeout_o    = timeout_q;

    case (state_q)
      IDLE: begin
        // The timeout cycle completes the stalled load with zero data; no new load starts here.
        if (timeout_q) begin
          load_valid_o = 1'b1;
        end else if (load_req_i) begin
          if (cache_hit_i) begin
            load_valid_o = 1'b1;
            load_data_o  = cache_data_i;
            hit_evt      = 1'b1;
          end else begin
            stall_o  = 1'b1;
            addr_d   = {addr_i[ADDR_WIDTH-1:2], 2'b00};
            miss_evt = 1'b1;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = addr_q;
        if (mem_ready_i) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        if (mem_rvalid_i) begin
          data_d  = mem_rdata_i;
          state_d = FILL;
        end else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      FILL: begin
        fill_o       = 1'b1;
        fill_addr_o  = addr_q;
        fill_data_o  = data_q;
        load_valid_o = 1'b1;
        load_data_o  = data_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_REFILL_STATS_EN
  // Saturating hit/miss counters, one count per load accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else begin
      if (hit_evt && (hit_count_o != 32'hFFFF_FFFF)) begin
        hit_count_o <= hit_count_o + 32'd1;
      end
      if (miss_evt && (miss_count_o != 32'hFFFF_FFFF)) begin
        miss_count_o <= miss_count_o + 32'd1;
      end
    end
  end
`else
  logic unused_stats;
  assign unused_stats = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_cache_refill_controller.sv
// Scoreboard bench for cache_refill_controller: a CPU/cache/memory model issues randomized loads,
// pushes expected responses, and an independent monitor compares them against DUT outputs.
module tb_cache_refill_controller;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned T  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_req;
  logic [AW-1:0] addr;
  logic          cache_hit;
  logic [DW-1:0] cache_data;
  logic          stall_o;
  logic          load_valid_o;
  logic [DW-1:0] load_data_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ready;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          fill_o;
  logic [AW-1:0] fill_addr_o;
  logic [DW-1:0] fill_data_o;
  logic          timeout_o;
`ifdef CACHE_REFILL_STATS_EN
  logic [31:0]   hit_count_o;
  logic [31:0]   miss_count_o;
`endif

  always #5 clk = ~clk;

  cache_refill_controller #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .load_req_i(load_req), .addr_i(addr), .cache_hit_i(cache_hit), .cache_data_i(cache_data),
    .stall_o(stall_o), .load_valid_o(load_valid_o), .load_data_o(load_data_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .fill_o(fill_o), .fill_addr_o(fill_addr_o), .fill_data_o(fill_data_o),
`ifdef CACHE_REFILL_STATS_EN
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o),
`endif
    .timeout_o(timeout_o)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          fill;
    logic [AW-1:0] faddr;
    logic [DW-1:0] fdata;
    logic          tmo;
    logic          stall;
  } resp_t;

  resp_t         exp_q[$];
  logic [AW-1:0] mem_q[$];
  logic [DW-1:0] cache_m[logic [AW-1:0]];
  logic [DW-1:0] mem_m[logic [AW-1:0]];
  int            checks = 0;
  int            failures = 0;
  int            model_hits = 0;
  int            model_misses = 0;
  bit            done = 1'b0;

  // One CPU load. The cache model decides hit/miss; a miss is answered by memory d cycles
  // after acceptance, which fills if d <= T and times out otherwise.
  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] mdata,
                       input int r, input int d, input logic rv_req);
    logic [AW-1:0] w;
    resp_t e;
    w = {a[AW-1:2], 2'b00};
    e = '0;
    @(negedge clk);
    load_req = 1'b1;
    addr     = a;
    if (cache_m.exists(w)) begin
      cache_hit  = 1'b1;
      cache_data = cache_m[w];
      e.data     = cache_m[w];
      exp_q.push_back(e);
      model_hits++;
      @(negedge clk);
      load_req   = 1'b0;
      cache_hit  = 1'b0;
      cache_data = $urandom;
    end else begin
      cache_hit  = 1'b0;
      cache_data = $urandom;
      mem_rdata  = mdata;
      model_misses++;
      mem_q.push_back(w);
      if (d <= int'(T)) begin
        e.data  = mdata;
        e.fill  = 1'b1;
        e.faddr = w;
        e.fdata = mdata;
        cache_m[w] = mdata;
      end else begin
        e.tmo = 1'b1;
      end
      exp_q.push_back(e);
      @(negedge clk);
      load_req = 1'b0;
      for (int i = 0; i < r; i++) begin
        mem_ready  = 1'b0;
        mem_rvalid = 1'($urandom);
        @(negedge clk);
      end
      mem_ready  = 1'b1;
      mem_rvalid = rv_req;
      for (int k = 1; k <= int'(T) + 2; k++) begin
        @(negedge clk);
        mem_ready  = 1'b0;
        mem_rvalid = (k == d);
      end
      @(negedge clk);
      mem_rvalid = 1'b0;
      @(negedge clk);
    end
  endtask

  // Miss that is accepted by memory, then killed by reset during the wait; late data follows.
  task automatic reset_mid_wait(input logic [AW-1:0] a);
    @(negedge clk);
    load_req  = 1'b1;
    addr      = a;
    cache_hit = 1'b0;
    mem_q.push_back({a[AW-1:2], 2'b00});
    @(negedge clk);
    load_req  = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1 rst_n  = 1'b0;
    model_hits   = 0;
    model_misses = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : stimulus
    logic [AW-1:0] a, w;
    rst_n = 1'b0; load_req = 1'b0; addr = '0; cache_hit = 1'b0; cache_data = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    cache_m[32'h40] = 32'hDEAD_BEEF;
    issue(32'h40, 32'h0, 0, 1, 1'b0);
    issue(32'h1003, 32'hCAFE_F00D, 2, 3, 1'b0);
    issue(32'h1000, 32'h0, 0, 1, 1'b0);
    issue(32'h2000, 32'h1111_2222, 0, int'(T) + 1, 1'b0);
    issue(32'h2000, 32'h3333_4444, 1, 2, 1'b0);
    reset_mid_wait(32'h5000);
    issue(32'h3000, 32'h1234_5678, 0, int'(T), 1'b1);
    issue(32'h3004, 32'h9ABC_DEF0, 1, 1, 1'b1);
    issue(32'h3008, 32'h5555_AAAA, 2, int'(T) + 2, 1'b1);

    for (int n = 0; n < 60; n++) begin
      a = AW'(32'h100) + AW'($urandom_range(0, 7) << 2) + AW'($urandom_range(0, 3));
      w = {a[AW-1:2], 2'b00};
      if (!mem_m.exists(w)) mem_m[w] = $urandom;
      if (($urandom_range(0, 3) == 0) && cache_m.exists(w)) cache_m.delete(w);
      issue(a, mem_m[w], int'($urandom_range(0, 2)), int'($urandom_range(1, T + 2)),
            1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    done = 1'b1;
  end

  initial begin : monitor
    bit    waiting;
    resp_t act, e;
    logic [AW-1:0] ea;
    waiting = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (done) break;
      if (!rst_n) begin
        waiting = 1'b0;
        checks++;
        if ({stall_o, load_valid_o, load_data_o, mem_req_o, mem_addr_o, fill_o, fill_addr_o,
             fill_data_o, timeout_o} != '0) begin
          failures++;
          $display("FAIL reset_outputs got stall=%b valid=%b data=%h req=%b maddr=%h fill=%b tmo=%b exp all 0",
                   stall_o, load_valid_o, load_data_o, mem_req_o, mem_addr_o, fill_o, timeout_o);
        end
        continue;
      end
      checks++;
      if ((!mem_req_o && mem_addr_o != '0) || (!fill_o && (fill_addr_o != '0 || fill_data_o != '0))) begin
        failures++;
        $display("FAIL bus_zero got maddr=%h faddr=%h fdata=%h req=%b fill=%b exp buses 0 when strobe low",
                 mem_addr_o, fill_addr_o, fill_data_o, mem_req_o, fill_o);
      end
      if (mem_req_o) begin
        checks++;
        if (!stall_o || mem_q.size() == 0) begin
          failures++;
          $display("FAIL mem_req got stall=%b pending=%0d exp stall=1 pending>0", stall_o, mem_q.size());
        end else if (mem_ready) begin
          checks++;
          ea = mem_q.pop_front();
          waiting = 1'b1;
          if (mem_addr_o != ea) begin
            failures++;
            $display("FAIL mem_addr got %h exp %h", mem_addr_o, ea);
          end
        end
      end
      if (load_valid_o) begin
        checks++;
        act = {load_data_o, fill_o, fill_addr_o, fill_data_o, timeout_o, stall_o};
        waiting = 1'b0;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_load got data=%h fill=%b tmo=%b exp no response", load_data_o, fill_o, timeout_o);
        end else begin
          e = exp_q.pop_front();
          if (act != e) begin
            failures++;
            $display("FAIL load_resp got data=%h fill=%b faddr=%h fdata=%h tmo=%b stall=%b exp data=%h fill=%b faddr=%h fdata=%h tmo=%b stall=%b",
                     act.data, act.fill, act.faddr, act.fdata, act.tmo, act.stall,
                     e.data, e.fill, e.faddr, e.fdata, e.tmo, e.stall);
          end
        end
      end else begin
        checks++;
        if (fill_o || timeout_o || (waiting && !stall_o)) begin
          failures++;
          $display("FAIL idle_strobes got fill=%b tmo=%b stall=%b waiting=%b exp fill=0 tmo=0 stall=waiting",
                   fill_o, timeout_o, stall_o, waiting);
        end
      end
    end

    checks++;
    if (exp_q.size() != 0 || mem_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending_resp=%0d pending_mem=%0d exp 0 and 0", exp_q.size(), mem_q.size());
    end
`ifdef CACHE_REFILL_STATS_EN
    checks++;
    if (hit_count_o != 32'(model_hits) || miss_count_o != 32'(model_misses)) begin
      failures++;
      $display("FAIL stats got hits=%0d misses=%0d exp hits=%0d misses=%0d",
               hit_count_o, miss_count_o, model_hits, model_misses);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
